wb_dma_master: RTL

Wishbone initiator that copies a block of 32-bit words from a source address range to a destination address range, one read then one write per word. It is the bus-master counterpart of the memory-mapped Wishbone peripherals such as the systolic-array slave. Typical uses are preloading the array's data and weight memory windows and draining results from them without CPU involvement. A simple start/busy/done command port is driven by a control register block or a sequencer.

---
 rtl/wb_dma_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/wb_dma_master.sv
// Wishbone block-copy initiator: reads a word from the source range, writes it
// to the destination range, and repeats until len words are copied, an error
// or timeout occurs, or the transfer is aborted.
module wb_dma_master #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 16,
  parameter int ADDR_STRIDE = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [3:0]            wb_sel_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  // Wait counter is wide enough to hold TIMEOUT itself.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]         TMO_LIMIT = CW'(TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(ADDR_STRIDE);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d, words_q, words_d, words_inc;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    err_q, err_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [3:0]              sel_q, sel_d;
  logic                    busy_q, busy_d, done_q, done_d;

  // Next-state logic; bus outputs are derived from the next state so that
  // every Wishbone output leaves a flop.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    data_d    = data_q;
    words_d   = words_q;
    err_d     = err_q;
    cnt_d     = '0;
    words_inc = words_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          err_d   = 1'b0;
          words_d = '0;
          state_d = (len == '0) ? FIN : RD;
        end
      end
      RD: begin
        // abort beats err, err beats ack, ack beats timeout
        if (abort) begin
          state_d = FIN;
        end else if (wb_err_i) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (wb_ack_i) begin
          data_d  = wb_dat_i;
          src_d   = src_q + STRIDE;
          state_d = WR;
        end else if (cnt_q == TMO_LIMIT) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR: begin
        if (abort) begin
          state_d = FIN;
        end else if (wb_err_i) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (wb_ack_i) begin
          dst_d   = dst_q + STRIDE;
          words_d = words_inc;
          state_d = (words_inc == len_q) ? FIN : RD;
        end else if (cnt_q == TMO_LIMIT) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cyc_d  = (state_d == RD) || (state_d == WR);
    stb_d  = cyc_d;
    we_d   = (state_d == WR);
    adr_d  = '0;
    if (state_d == RD) begin
      adr_d = src_d;
    end else if (state_d == WR) begin
      adr_d = dst_d;
    end
    sel_d  = stb_d ? 4'hF : 4'h0;
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      data_q  <= data_d;
      words_q <= words_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign words_done = words_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = data_q;
  assign wb_sel_o   = sel_q;

endmodule
